mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 225 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
//
// Memory-access pipeline stage. Takes one EX result per accepted cycle and
// either passes it straight through (no memory op), flags it as misaligned,
// or runs a single-beat data-bus transaction and returns the load data,
// sign/zero-extended, for writeback.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   valid_in, mem_op, addr,  EX result: op code, effective address (or
//   store_data, wb_reg_in    passthrough value), store data, dest tag
//   busy                     stall request upstream (high in BUS and DONE)
//   valid_out, result,       one-cycle completion pulse with load data or
//   wb_reg_out               passthrough value and destination tag
//   addr_err_load/store,     misaligned access flags and faulting address,
//   bad_addr                 qualified by valid_out
//   bus_req, bus_we,         data-bus request: word address, little-endian
//   bus_addr, bus_be,        byte enables, lane-replicated write data
//   bus_wdata
//   bus_ack, bus_rdata       bus completion and read word (same cycle)
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [3:0]   mem_op,
    input  logic [W-1:0] addr,
    input  logic [W-1:0] store_data,
    input  logic [4:0]   wb_reg_in,
    output logic         busy,
    output logic         valid_out,
    output logic [W-1:0] result,
    output logic [4:0]   wb_reg_out,
    output logic         addr_err_load,
    output logic         addr_err_store,
    output logic [W-1:0] bad_addr,
    output logic         bus_req,
    output logic         bus_we,
    output logic [W-1:0] bus_addr,
    output logic [3:0]   bus_be,
    output logic [W-1:0] bus_wdata,
    input  logic         bus_ack,
    input  logic [W-1:0] bus_rdata
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_DONE
    } state_e;

    state_e       state;
    logic [3:0]   op_q;
    logic [1:0]   off_q;
    logic [4:0]   tag_q;
    logic [W-1:0] rdata_q;

    // Decode of the incoming request.
    logic         is_load;
    logic         is_store;
    logic         is_half;
    logic         is_word;
    logic         misaligned;
    logic [3:0]   be_c;
    logic [W-1:0] wdata_c;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value unassigned (no latch).
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        be_c     = 4'b0000;
        wdata_c  = store_data;
        case (mem_op)
            OP_LB, OP_LBU: begin
                is_load = 1'b1;
                be_c    = 4'b0001 << addr[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1;
                is_half = 1'b1;
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
            end
            OP_LW: begin
                is_load = 1'b1;
                is_word = 1'b1;
                be_c    = 4'b1111;
            end
            OP_SB: begin
                is_store = 1'b1;
                be_c     = 4'b0001 << addr[1:0];
                wdata_c  = {(W/8){store_data[7:0]}};
            end
            OP_SH: begin
                is_store = 1'b1;
                is_half  = 1'b1;
                be_c     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c  = {(W/16){store_data[15:0]}};
            end
            OP_SW: begin
                is_store = 1'b1;
                is_word  = 1'b1;
                be_c     = 4'b1111;
            end
            default: ; // NONE and the unused codes 9-15 pass through
        endcase
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    end

    // Pull the addressed byte/half down to bit 0 and extend it. Stores
    // complete with a zero result.
    function automatic logic [W-1:0] load_extract(input logic [3:0]   op,
                                                  input logic [1:0]   off,
                                                  input logic [W-1:0] word);
        logic [W-1:0] sh;
        sh = word >> {off, 3'b000};
        case (op)
            OP_LB:   return {{(W-8){sh[7]}}, sh[7:0]};
            OP_LBU:  return {{(W-8){1'b0}}, sh[7:0]};
            OP_LH:   return {{(W-16){sh[15]}}, sh[15:0]};
            OP_LHU:  return {{(W-16){1'b0}}, sh[15:0]};
            OP_LW:   return word;
            default: return '0;
        endcase
    endfunction

    // NOTE: state and outputs are registers, so they use non-blocking
    // assignments; every reader sees the pre-edge value regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            valid_out      <= 1'b0;
            result         <= '0;
            wb_reg_out     <= '0;
            addr_err_load  <= 1'b0;
            addr_err_store <= 1'b0;
            bad_addr       <= '0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_be         <= 4'b0000;
            bus_wdata      <= '0;
            op_q           <= '0;
            off_q          <= '0;
            tag_q          <= '0;
            rdata_q        <= '0;
        end else begin
            // Completion qualifiers are pulses; result and wb_reg_out hold
            // their last value between completions.
            valid_out      <= 1'b0;
            addr_err_load  <= 1'b0;
            addr_err_store <= 1'b0;
            bad_addr       <= '0;

            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (!(is_load || is_store)) begin
                            valid_out  <= 1'b1;
                            result     <= addr;
                            wb_reg_out <= wb_reg_in;
                        end else if (misaligned) begin
                            valid_out      <= 1'b1;
                            addr_err_load  <= is_load;
                            addr_err_store <= is_store;
                            bad_addr       <= addr;
                            result         <= '0;
                            wb_reg_out     <= wb_reg_in;
                        end else begin
                            op_q      <= mem_op;
                            off_q     <= addr[1:0];
                            tag_q     <= wb_reg_in;
                            bus_req   <= 1'b1;
                            bus_we    <= is_store;
                            bus_addr  <= {addr[W-1:2], 2'b00};
                            bus_be    <= be_c;
                            bus_wdata <= wdata_c;
                            busy      <= 1'b1;
                            state     <= S_BUS;
                        end
                    end
                end

                S_BUS: begin
                    // Request lines hold until the ack; no timeout.
                    if (bus_ack) begin
                        rdata_q <= bus_rdata;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    valid_out  <= 1'b1;
                    result     <= load_extract(op_q, off_q, rdata_q);
                    wb_reg_out <= tag_q;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Directed bench for mem_access. Expected completions are pushed to a
// scoreboard when an op is driven; a negedge monitor pops and compares them
// whenever valid_out is seen, including the cycle it was due.
// -----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  wb_reg_in;
    logic        busy;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  wb_reg_out;
    logic        addr_err_load;
    logic        addr_err_store;
    logic [31:0] bad_addr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  tag;
        logic        err_load;
        logic        err_store;
        logic [31:0] bad;
        int          due;
    } exp_t;

    exp_t sb[$];

    mem_access #(.W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .mem_op         (mem_op),
        .addr           (addr),
        .store_data     (store_data),
        .wb_reg_in      (wb_reg_in),
        .busy           (busy),
        .valid_out      (valid_out),
        .result         (result),
        .wb_reg_out     (wb_reg_out),
        .addr_err_load  (addr_err_load),
        .addr_err_store (addr_err_store),
        .bad_addr       (bad_addr),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load result: pick the addressed lane directly out of the word.
    function automatic logic [31:0] model_result(input logic [3:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[int'(a[1:0]) * 8 +: 8];
        h = rd[int'(a[1]) * 16 +: 16];
        case (op)
            4'd1:    return {{24{b[7]}}, b};
            4'd2:    return {24'h0, b};
            4'd3:    return {{16{h[15]}}, h};
            4'd4:    return {16'h0, h};
            4'd5:    return rd;
            default: return 32'h0;
        endcase
    endfunction

    // Completion monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_out", 32'(valid_out), 32'h0);
            end else begin
                e = sb.pop_front();
                check("result",         result,                   e.result);
                check("wb_reg_out",     32'(wb_reg_out),          32'(e.tag));
                check("addr_err_load",  32'(addr_err_load),       32'(e.err_load));
                check("addr_err_store", 32'(addr_err_store),      32'(e.err_store));
                check("bad_addr",       bad_addr,                 e.bad);
                check("completion_cycle", 32'(cycle),             32'(e.due));
            end
        end else begin
            check("idle_qualifiers",
                  {29'h0, addr_err_load, addr_err_store, |bad_addr}, 32'h0);
        end
    end

    // Drive one request for one cycle; returns at the following negedge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] tag);
        valid_in   = 1'b1;
        mem_op     = op;
        addr       = a;
        store_data = sd;
        wb_reg_in  = tag;
        @(negedge clk);
        valid_in   = 1'b0;
        mem_op     = 4'd0;
    endtask

    // Passthrough or misaligned op: completes the next cycle, no bus.
    task automatic imm_txn(input logic [3:0] op, input logic [31:0] a,
                           input logic [4:0] tag, input logic [31:0] exp_res,
                           input logic el, input logic es, input logic [31:0] bad);
        exp_t e;
        e.result    = exp_res;
        e.tag       = tag;
        e.err_load  = el;
        e.err_store = es;
        e.bad       = bad;
        e.due       = cycle + 1;
        sb.push_back(e);
        issue(op, a, 32'h0BAD_F00D, tag);
        check("imm_no_bus_req", 32'(bus_req), 32'h0);
        check("imm_not_busy",   32'(busy),    32'h0);
    endtask

    // Aligned memory op with a bus ack after 'delay' extra BUS cycles.
    // 'poke' pulses valid_in during the first stalled cycle.
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input logic [4:0] tag, input int delay, input bit poke);
        exp_t        e;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        st;
        st = (op >= 4'd6);
        case (op)
            4'd1, 4'd2, 4'd6: e_be = 4'b0001 << a[1:0];
            4'd3, 4'd4, 4'd7: e_be = a[1] ? 4'b1100 : 4'b0011;
            default:          e_be = 4'b1111;
        endcase
        case (op)
            4'd6:    e_wd = {4{sd[7:0]}};
            4'd7:    e_wd = {2{sd[15:0]}};
            default: e_wd = sd;
        endcase
        e.result    = model_result(op, a, rd);
        e.tag       = tag;
        e.err_load  = 1'b0;
        e.err_store = 1'b0;
        e.bad       = 32'h0;
        e.due       = cycle + 3 + delay;
        sb.push_back(e);

        issue(op, a, sd, tag);
        check("bus_req",  32'(bus_req), 32'h1);
        check("bus_we",   32'(bus_we),  32'(st));
        check("bus_be",   32'(bus_be),  32'(e_be));
        check("bus_addr", bus_addr,     {a[31:2], 2'b00});
        if (st) check("bus_wdata", bus_wdata, e_wd);
        check("busy_bus", 32'(busy),    32'h1);

        for (int i = 0; i < delay; i++) begin
            if (poke && i == 0) begin
                valid_in  = 1'b1;
                mem_op    = 4'd0;
                addr      = 32'h5555_5555;
                wb_reg_in = 5'd31;
            end
            @(negedge clk);
            valid_in = 1'b0;
            check("hold_bus_req",  32'(bus_req), 32'h1);
            check("hold_bus_be",   32'(bus_be),  32'(e_be));
            check("hold_bus_addr", bus_addr,     {a[31:2], 2'b00});
            if (st) check("hold_bus_wdata", bus_wdata, e_wd);
            check("hold_busy",     32'(busy),    32'h1);
        end

        bus_ack   = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        check("bus_req_drop", 32'(bus_req), 32'h0);
        check("busy_done",    32'(busy),    32'h1);
        @(negedge clk);
        check("busy_release", 32'(busy),    32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        mem_op     = 4'd0;
        addr       = 32'h0;
        store_data = 32'h0;
        wb_reg_in  = 5'd0;
        bus_ack    = 1'b0;
        bus_rdata  = 32'h0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy",       32'(busy),           32'h0);
        check("rst_valid_out",  32'(valid_out),      32'h0);
        check("rst_result",     result,              32'h0);
        check("rst_wb_reg_out", 32'(wb_reg_out),     32'h0);
        check("rst_err",        {30'h0, addr_err_load, addr_err_store}, 32'h0);
        check("rst_bus_ctl",    {30'h0, bus_req, bus_we}, 32'h0);
        check("rst_bus_addr",   bus_addr,            32'h0);
        check("rst_bus_be",     32'(bus_be),         32'h0);
        check("rst_bus_wdata",  bus_wdata,           32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Passthrough and misaligned ops.
        imm_txn(4'd0,  32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        imm_txn(4'd12, 32'h1357_9BDF, 5'd4,  32'h1357_9BDF, 1'b0, 1'b0, 32'h0);
        imm_txn(4'd5,  32'h0000_0006, 5'd3,  32'h0,         1'b1, 1'b0, 32'h6);
        imm_txn(4'd7,  32'h0000_2003, 5'd5,  32'h0,         1'b0, 1'b1, 32'h2003);
        imm_txn(4'd4,  32'h0000_0011, 5'd6,  32'h0,         1'b1, 1'b0, 32'h11);

        // Memory ops: minimum latency, stalled acks, each width and extension.
        mem_txn(4'd1, 32'h0000_1003, 32'h0,         32'h80FF_FF12, 5'd1,  0, 1'b0);
        mem_txn(4'd7, 32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 5'd2,  5, 1'b1);
        mem_txn(4'd2, 32'h0000_1001, 32'h0,         32'h1234_80AB, 5'd7,  0, 1'b0);
        mem_txn(4'd3, 32'h0000_0402, 32'h0,         32'h8001_7FFF, 5'd8,  1, 1'b0);
        mem_txn(4'd4, 32'h0000_0400, 32'h0,         32'h1234_F00D, 5'd10, 0, 1'b0);
        mem_txn(4'd5, 32'h0000_0800, 32'h0,         32'hCAFE_BABE, 5'd11, 2, 1'b1);
        mem_txn(4'd6, 32'h0000_3001, 32'h0000_AA55, 32'h0,         5'd12, 0, 1'b0);
        mem_txn(4'd8, 32'h0000_4000, 32'h0102_0304, 32'h0,         5'd13, 1, 1'b0);

        // Stray ack while idle is ignored.
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_7777;
        @(negedge clk);
        bus_ack   = 1'b0;
        @(negedge clk);
        check("stray_ack_busy",    32'(busy),    32'h0);
        check("stray_ack_bus_req", 32'(bus_req), 32'h0);

        // Reset in the middle of a bus transaction, then a late ack.
        issue(4'd4, 32'h0000_0010, 32'h0, 5'd14);
        check("abort_bus_req", 32'(bus_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_rst_bus_req", 32'(bus_req), 32'h0);
        check("abort_rst_busy",    32'(busy),    32'h0);
        check("abort_rst_bus_be",  32'(bus_be),  32'h0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hAAAA_5555;
        @(negedge clk);
        bus_ack   = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_late_busy",    32'(busy),    32'h0);
        check("abort_late_bus_req", 32'(bus_req), 32'h0);

        // Recovery after the aborted transaction.
        mem_txn(4'd5, 32'h0000_0010, 32'h0, 32'h0BAD_CAFE, 5'd15, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
